// File: rtl/yarp_pkg.sv
// Shared types for the yarp core data-memory path.
// Access sizes, responder states and vector geometry.
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_t;

    typedef enum logic [1:0] {
        IDLE,
        SWAIT,
        VBEAT,
        RESP
    } dmem_state_e;

    localparam int VEC_ROWS = 4;
    localparam int VEC_W    = 128;

    typedef struct packed {
        logic             wr;
        mem_access_size_t size;
        logic             zext;
        logic [1:0]       addr_lo;
    } dmem_req_t;

endpackage

// File: rtl/yarp_dmem_lane_align.sv
// Byte-lane handling for scalar accesses: store mask/merge
// into the old word, and load extract with sign/zero extension.
module yarp_dmem_lane_align
    import yarp_pkg::*;
(
    input  mem_access_size_t size,
    input  logic [1:0]       addr_lo,
    input  logic             zero_extnd,
    input  logic [31:0]      wr_data,
    input  logic [31:0]      old_word,
    input  logic [31:0]      rd_word,
    output logic [31:0]      wr_word,
    output logic [31:0]      rd_data
);

    logic [31:0] mask;
    logic [31:0] lanes;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        mask    = '1;
        lanes   = wr_data;
        rd_byte = rd_word[{addr_lo, 3'b000} +: 8];
        rd_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        rd_data = rd_word;
        unique case (1'b1)
            size == BYTE: begin
                mask    = 32'h0000_00FF << {addr_lo, 3'b000};
                lanes   = {4{wr_data[7:0]}};
                rd_data = zero_extnd ? {24'b0, rd_byte}
                                     : {{24{rd_byte[7]}}, rd_byte};
            end
            size == HALF_WORD: begin
                mask    = addr_lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lanes   = {2{wr_data[15:0]}};
                rd_data = zero_extnd ? {16'b0, rd_half}
                                     : {{16{rd_half[15]}}, rd_half};
            end
            default: ;
        endcase
        wr_word = (old_word & ~mask) | (lanes & mask);
    end

endmodule

// File: rtl/yarp_dmem_responder.sv
// Memory-side responder for the core data interface: scalar
// loads/stores with configurable read latency, 4-beat vector rows.
module yarp_dmem_responder
    import yarp_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            data_req_i,
    input  logic                            data_wr_i,
    input  logic [31:0]                     data_addr_i,
    input  logic [1:0]                      data_byte_en_i,
    input  logic                            data_zero_extnd_i,
    input  logic [31:0]                     data_wr_data_i,
    input  logic                            is_vector_i,
    input  logic [VEC_ROWS-1:0][VEC_W-1:0]  vec_wr_data_i,
    output logic                            data_ready_o,
    output logic                            rsp_valid_o,
    output logic                            rsp_err_o,
    output logic [31:0]                     rsp_rd_data_o,
    output logic [VEC_ROWS-1:0][VEC_W-1:0]  vec_rsp_rd_data_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    typedef logic [IDX_W-1:0] idx_t;

    dmem_state_e                    state;
    dmem_req_t                      req_q;
    idx_t                           idx_q;
    logic [VEC_ROWS-1:0][VEC_W-1:0] vec_wr_q;
    logic [2:0]                     lat_cnt;
    logic [1:0]                     beat;
    logic [31:0]                    mem [MEM_WORDS];

    mem_access_size_t size_in;
    logic             accept;
    logic             misaligned;
    idx_t             cur_idx;
    idx_t             al_idx;
    idx_t             row_base;
    mem_access_size_t al_size;
    logic [1:0]       al_lo;
    logic             al_zext;
    logic [31:0]      wr_word;
    logic [31:0]      ld_data;
    logic             unused_addr_hi;

    assign size_in        = mem_access_size_t'(data_byte_en_i);
    assign data_ready_o   = (state == IDLE) && !reset;
    assign accept         = data_req_i && data_ready_o;
    assign cur_idx        = data_addr_i[IDX_W+1:2];
    assign unused_addr_hi = ^data_addr_i[31:IDX_W+2];
    assign row_base       = idx_q + idx_t'({beat, 2'b00});
    assign rsp_valid_o    = (state == RESP);

    always_comb begin
        misaligned = 1'b0;
        unique case (1'b1)
            is_vector_i:          misaligned = |data_addr_i[3:0];
            size_in == BYTE:      misaligned = 1'b0;
            size_in == HALF_WORD: misaligned = data_addr_i[0];
            default:              misaligned = |data_addr_i[1:0];
        endcase
    end

    // IDLE serves the live request; later states use the latched one.
    always_comb begin
        if (state == IDLE) begin
            al_idx  = cur_idx;
            al_size = size_in;
            al_lo   = data_addr_i[1:0];
            al_zext = data_zero_extnd_i;
        end else begin
            al_idx  = idx_q;
            al_size = req_q.size;
            al_lo   = req_q.addr_lo;
            al_zext = req_q.zext;
        end
    end

    yarp_dmem_lane_align u_align (
        .size       (al_size),
        .addr_lo    (al_lo),
        .zero_extnd (al_zext),
        .wr_data    (data_wr_data_i),
        .old_word   (mem[al_idx]),
        .rd_word    (mem[al_idx]),
        .wr_word    (wr_word),
        .rd_data    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (accept && !misaligned && data_wr_i && !is_vector_i)
            mem[cur_idx] <= wr_word;
        if (state == VBEAT && req_q.wr) begin
            for (int j = 0; j < 4; j++)
                mem[row_base + idx_t'(j)] <= vec_wr_q[beat][32*j +: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            req_q             <= '0;
            idx_q             <= '0;
            vec_wr_q          <= '0;
            lat_cnt           <= '0;
            beat              <= '0;
            rsp_err_o         <= 1'b0;
            rsp_rd_data_o     <= '0;
            vec_rsp_rd_data_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        req_q     <= '{wr: data_wr_i, size: size_in,
                                       zext: data_zero_extnd_i,
                                       addr_lo: data_addr_i[1:0]};
                        idx_q     <= cur_idx;
                        vec_wr_q  <= vec_wr_data_i;
                        beat      <= '0;
                        rsp_err_o <= 1'b0;
                        if (misaligned) begin
                            rsp_err_o     <= 1'b1;
                            rsp_rd_data_o <= '0;
                            state         <= RESP;
                        end else if (is_vector_i) begin
                            state <= VBEAT;
                        end else if (data_wr_i) begin
                            state <= RESP;
                        end else if (RD_LATENCY <= 1) begin
                            rsp_rd_data_o <= ld_data;
                            state         <= RESP;
                        end else begin
                            lat_cnt <= 3'(RD_LATENCY - 1);
                            state   <= SWAIT;
                        end
                    end
                end
                SWAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        rsp_rd_data_o <= ld_data;
                        state         <= RESP;
                    end
                end
                VBEAT: begin
                    if (!req_q.wr) begin
                        for (int j = 0; j < 4; j++)
                            vec_rsp_rd_data_o[beat][32*j +: 32]
                                <= mem[row_base + idx_t'(j)];
                    end
                    beat <= beat + 2'd1;
                    if (beat == 2'd3)
                        state <= RESP;
                end
                RESP: begin
                    rsp_err_o <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
